// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, PC+1 adder, branch redirect and a direct-mapped
// instruction cache refilled one whole line at a time from instruction memory.
module instr_fetch_unit #(
   parameter int               ADDR_W         = 16,
   parameter int               INSTR_W        = 16,
   parameter int               WORDS_PER_LINE = 4,
   parameter int               NUM_LINES      = 8,
   parameter logic [ADDR_W-1:0] RESET_PC      = '0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_pc_src,
   input  logic [ADDR_W-1:0]                 i_branch_target,
   input  logic                              i_stall,
   input  logic                              i_flush,
   output logic [INSTR_W-1:0]                o_instr_out,
   output logic                              o_instr_valid,
   output logic                              o_hit,
   output logic [ADDR_W-1:0]                 o_pc_out,
   output logic [ADDR_W-1:0]                 o_adder_out,
   output logic                              o_mem_req,
   output logic [ADDR_W-1:0]                 o_mem_addr,
   input  logic                              i_mem_ready,
   input  logic [INSTR_W*WORDS_PER_LINE-1:0] i_mem_line,
   output logic [15:0]                       o_hit_count,
   output logic [15:0]                       o_miss_count,
   output logic                              o_dbg_state
);

   localparam int OB     = $clog2(WORDS_PER_LINE);
   localparam int IB     = $clog2(NUM_LINES);
   localparam int TW     = ADDR_W - OB - IB;
   localparam int LINE_W = INSTR_W * WORDS_PER_LINE;

   typedef enum logic {
      S_RUN    = 1'b0,
      S_REFILL = 1'b1
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [ADDR_W-1:0]    r_pc;
   logic [ADDR_W-1:0]    w_pc_nxt;
   logic [ADDR_W-1:0]    w_pc_inc;
   logic [ADDR_W-1:0]    r_pend;
   logic                 r_pend_v;
   logic                 r_mem_req;
   logic [ADDR_W-1:0]    r_mem_addr;
   logic [15:0]          r_hit_count;
   logic [15:0]          r_miss_count;
   logic [NUM_LINES-1:0] r_valid;
   logic [TW-1:0]        r_tag  [NUM_LINES];
   logic [LINE_W-1:0]    r_data [NUM_LINES];

   logic [OB-1:0]        w_offset;
   logic [IB-1:0]        w_index;
   logic [TW-1:0]        w_tag;
   logic [IB-1:0]        w_fill_index;
   logic [TW-1:0]        w_fill_tag;
   logic [LINE_W-1:0]    w_line;
   logic                 w_lookup_hit;
   logic                 w_miss;
   logic                 w_fill_done;
   logic                 w_count_hit;

   assign w_offset     = r_pc[OB-1:0];
   assign w_index      = r_pc[OB +: IB];
   assign w_tag        = r_pc[ADDR_W-1 -: TW];
   assign w_fill_index = r_mem_addr[OB +: IB];
   assign w_fill_tag   = r_mem_addr[ADDR_W-1 -: TW];
   assign w_line       = r_data[w_index];
   assign w_lookup_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_pc_inc     = r_pc + 1'b1;

   assign o_instr_out  = w_line[w_offset*INSTR_W +: INSTR_W];
   assign o_pc_out     = r_pc;
   assign o_adder_out  = w_pc_inc;
   assign o_mem_req    = r_mem_req;
   assign o_mem_addr   = r_mem_addr;
   assign o_hit_count  = r_hit_count;
   assign o_miss_count = r_miss_count;
   assign o_dbg_state  = r_state;

   // Line-fill handshake: o_mem_req is valid, i_mem_ready is ready+data. The
   // request and its address stay stable until ready is sampled high on a
   // rising edge; that edge consumes i_mem_line. Ready with no request is ignored.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_miss        = 1'b0;
      w_fill_done   = 1'b0;
      w_count_hit   = 1'b0;
      o_hit         = 1'b0;
      o_instr_valid = 1'b0;
      case (r_state)
         S_RUN: begin
            o_hit         = w_lookup_hit;
            o_instr_valid = w_lookup_hit && !i_pc_src;
            if (i_pc_src) begin
               w_pc_nxt = i_branch_target;
            end else if (w_lookup_hit) begin
               if (!i_stall) begin
                  w_pc_nxt    = w_pc_inc;
                  w_count_hit = 1'b1;
               end
            end else begin
               w_state_nxt = S_REFILL;
               w_miss      = 1'b1;
            end
         end
         S_REFILL: begin
            if (i_mem_ready) begin
               w_state_nxt = S_RUN;
               w_fill_done = 1'b1;
               // A redirect on the completing edge is the latest one.
               if (i_pc_src) begin
                  w_pc_nxt = i_branch_target;
               end else if (r_pend_v) begin
                  w_pc_nxt = r_pend;
               end
            end
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_pend       <= '0;
         r_pend_v     <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_addr   <= '0;
         r_hit_count  <= '0;
         r_miss_count <= '0;
         r_valid      <= '0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_miss) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_pc[ADDR_W-1:OB], {OB{1'b0}}};
         end else if (w_fill_done) begin
            r_mem_req <= 1'b0;
         end
         if (r_state == S_REFILL) begin
            if (w_fill_done) begin
               r_pend_v <= 1'b0;
            end else if (i_pc_src) begin
               r_pend   <= i_branch_target;
               r_pend_v <= 1'b1;
            end
         end
         // Flush wins over a fill landing on the same edge.
         if (i_flush) begin
            r_valid <= '0;
         end else if (w_fill_done) begin
            r_valid[w_fill_index] <= 1'b1;
         end
         if (w_count_hit && (r_hit_count != 16'hFFFF)) begin
            r_hit_count <= r_hit_count + 16'd1;
         end
         if (w_miss && (r_miss_count != 16'hFFFF)) begin
            r_miss_count <= r_miss_count + 16'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_tag[w_fill_index]  <= w_fill_tag;
         r_data[w_fill_index] <= i_mem_line;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then random traffic, all
// checked against a line-address-level cache and memory model.
module tb_instr_fetch_unit;

   localparam int AW  = 16;
   localparam int IW  = 16;
   localparam int WPL = 4;
   localparam int NL  = 8;
   localparam int LW  = IW * WPL;

   logic          clk = 1'b0;
   logic          rst;
   logic          pc_src;
   logic [AW-1:0] branch_target;
   logic          stall;
   logic          flush;
   logic          mem_ready;
   logic [LW-1:0] mem_line;
   logic [IW-1:0] instr_out;
   logic          instr_valid;
   logic          hit;
   logic [AW-1:0] pc_out;
   logic [AW-1:0] adder_out;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [15:0]   hit_count;
   logic [15:0]   miss_count;
   logic          dbg_state;

   instr_fetch_unit #(
      .ADDR_W(AW), .INSTR_W(IW), .WORDS_PER_LINE(WPL), .NUM_LINES(NL),
      .RESET_PC(16'h0000)
   ) dut (
      .clk(clk), .rst(rst),
      .i_pc_src(pc_src), .i_branch_target(branch_target),
      .i_stall(stall), .i_flush(flush),
      .o_instr_out(instr_out), .o_instr_valid(instr_valid), .o_hit(hit),
      .o_pc_out(pc_out), .o_adder_out(adder_out),
      .o_mem_req(mem_req), .o_mem_addr(mem_addr),
      .i_mem_ready(mem_ready), .i_mem_line(mem_line),
      .o_hit_count(hit_count), .o_miss_count(miss_count),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: the cache is a map slot -> cached line address (-1 empty).
   logic [AW-1:0] m_pc;
   logic [AW-1:0] m_fill;
   logic [AW-1:0] m_pend;
   bit            m_refill;
   bit            m_pend_v;
   int            m_slot [NL];
   int            m_hits;
   int            m_misses;

   function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
      logic [31:0] t;
      t = {16'h0, a} * 32'd40503 + 32'd7;
      return t[IW-1:0] ^ t[31:16];
   endfunction

   function automatic logic [LW-1:0] line_data(input logic [AW-1:0] base);
      logic [LW-1:0] r;
      r = '0;
      for (int w = 0; w < WPL; w++) r[w*IW +: IW] = mem_word(base + AW'(w));
      return r;
   endfunction

   function automatic int line_of(input logic [AW-1:0] a);
      return int'(a) / WPL;
   endfunction

   function automatic int slot_of(input logic [AW-1:0] a);
      return line_of(a) % NL;
   endfunction

   function automatic bit model_hit();
      return !m_refill && (m_slot[slot_of(m_pc)] == line_of(m_pc));
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_fill = '0; m_pend = '0;
      m_refill = 0; m_pend_v = 0; m_hits = 0; m_misses = 0;
      for (int i = 0; i < NL; i++) m_slot[i] = -1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs, advance the model on posedge.
   task automatic cyc(input bit s, input logic [AW-1:0] t, input bit st,
                      input bit fl, input bit rdy);
      bit            eh;
      logic [AW-1:0] e_add;
      pc_src = s; branch_target = t; stall = st; flush = fl; mem_ready = rdy;
      mem_line = m_refill ? line_data(m_fill) : {$urandom, $urandom};
      #1;
      eh    = model_hit();
      e_add = m_pc + 1'b1;
      chk("pc_out", pc_out, m_pc);
      chk("adder_out", adder_out, e_add);
      chk("hit", hit, eh);
      chk("instr_valid", instr_valid, eh && !s);
      if (eh && !s) chk("instr_out", instr_out, mem_word(m_pc));
      chk("mem_req", mem_req, m_refill);
      if (m_refill) chk("mem_addr", mem_addr, m_fill);
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
      @(posedge clk);
      if (!m_refill) begin
         if (s) m_pc = t;
         else if (eh) begin
            if (!st) begin
               m_pc = m_pc + 1'b1;
               if (m_hits < 65535) m_hits++;
            end
         end else begin
            m_refill = 1;
            m_fill   = m_pc & ~AW'(WPL - 1);
            if (m_misses < 65535) m_misses++;
         end
      end else begin
         if (s) begin m_pend = t; m_pend_v = 1; end
         if (rdy) begin
            m_slot[slot_of(m_fill)] = line_of(m_fill);
            m_refill = 0;
            if (m_pend_v) m_pc = m_pend;
            m_pend_v = 0;
         end
      end
      if (fl) for (int i = 0; i < NL; i++) m_slot[i] = -1;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] hc_before;
      rst = 1'b1; pc_src = 0; branch_target = '0; stall = 0; flush = 0;
      mem_ready = 0; mem_line = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_mem_addr", mem_addr, 16'h0000);
      chk("reset_pc", pc_out, 16'h0000);

      // Cold miss at 0, fill after 3 cycles, then A..D back to back.
      cyc(0, 0, 0, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      repeat (4) cyc(0, 0, 0, 0, 0);
      chk("tp1_hits", hit_count, 16'd4);
      chk("tp1_misses", miss_count, 16'd1);

      // Line boundary 3 -> 4 misses.
      cyc(0, 0, 0, 0, 0);
      chk("tp2_mem_addr", mem_addr, 16'h0004);
      chk("tp2_misses", miss_count, 16'd2);
      cyc(0, 0, 0, 0, 1);

      // Redirect while hitting at 3.
      cyc(1, 16'h0003, 0, 0, 0);
      cyc(1, 16'h0002, 0, 0, 0);
      chk("tp3_pc", pc_out, 16'h0002);
      chk("tp3_hit", hit, 1'b1);

      // Two redirects during a refill, last wins.
      cyc(1, 16'h0010, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(1, 16'h0010, 0, 0, 0);
      cyc(1, 16'h0020, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("tp4_pc", pc_out, 16'h0020);
      cyc(0, 0, 0, 0, 0);
      chk("tp4_mem_addr", mem_addr, 16'h0020);
      cyc(0, 0, 0, 0, 1);

      // Stall holds PC and hit count; flush forces a miss.
      hc_before = hit_count;
      repeat (3) cyc(0, 0, 1, 0, 0);
      chk("tp5_pc", pc_out, 16'h0020);
      chk("tp5_hits", hit_count, hc_before);
      cyc(0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("tp5_miss_req", mem_req, 1'b1);
      cyc(0, 0, 0, 0, 1);

      // PC wrap at 0xFFFF, then async reset in the middle of a refill.
      cyc(1, 16'hFFFF, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1);
      chk("tp6_adder", adder_out, 16'h0000);
      cyc(0, 0, 0, 0, 0);
      chk("tp6_wrap_pc", pc_out, 16'h0000);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("rst_mid_mem_req", mem_req, 1'b0);
      chk("rst_mid_pc", pc_out, 16'h0000);
      chk("rst_mid_hit", hit, 1'b0);
      chk("rst_mid_misses", miss_count, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         bit            s, st, fl, rdy;
         logic [AW-1:0] t;
         s   = ($urandom_range(0, 9) == 0);
         t   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 63));
         st  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 29) == 0);
         rdy = ($urandom_range(0, 2) == 0);
         cyc(s, t, st, fl, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
